// File: rtl/vmem_console_ctrl.sv
// vmem_console_ctrl: text-console sequencer driving the video RAM write port from ASCII keys.
// Optional WRAP_CLEAR_EN: a row advance out of the last row clears the screen.
module vmem_console_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW = 12,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    output logic          key_ready,
    output logic [AW-1:0] vm_addr,
    output logic [7:0]    vm_data,
    output logic          vm_we,
    output logic [4:0]    cur_row,
    output logic [6:0]    cur_col,
    output logic          busy
);
    localparam int N = COLS * ROWS;
`ifdef WRAP_CLEAR_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    typedef enum logic [1:0] {CLEAR, IDLE, EXEC} state_t;
    state_t state;
    logic [AW:0] ptr;
    logic to_clear, is_print, is_nl, is_bs, last_col, last_row, n_we, go_clear;
    logic [4:0] inc_row, n_row;
    logic [6:0] n_col;
    logic [AW-1:0] wr_addr;
    // Next cursor and write target are resolved in the accept cycle and registered into EXEC.
    always_comb begin
        is_print = key_ascii >= 8'h20 && key_ascii <= 8'h7e;
        is_nl = key_ascii == 8'h0d || key_ascii == 8'h0a;
        is_bs = key_ascii == 8'h08;
        last_col = cur_col == 7'(COLS - 1);
        last_row = cur_row == 5'(ROWS - 1);
        inc_row = last_row ? 5'd0 : cur_row + 5'd1;
        n_row = (is_print && last_col) || is_nl ? inc_row :
                is_bs && cur_col == 7'd0 && cur_row != 5'd0 ? cur_row - 5'd1 : cur_row;
        n_col = is_print ? (last_col ? 7'd0 : cur_col + 7'd1) : is_nl ? 7'd0 :
                is_bs ? (cur_col != 7'd0 ? cur_col - 7'd1 : cur_row != 5'd0 ? 7'(COLS - 1) : 7'd0) : cur_col;
        n_we = is_print || is_bs;
        wr_addr = is_bs ? AW'(n_row) * AW'(COLS) + AW'(n_col) : AW'(cur_row) * AW'(COLS) + AW'(cur_col);
        go_clear = key_ascii == 8'h0c || (WRAP && last_row && ((is_print && last_col) || is_nl));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr <= '0;
            cur_row <= 5'd0;
            cur_col <= 7'd0;
            vm_we <= 1'b0;
            vm_addr <= '0;
            vm_data <= BLANK;
            key_ready <= 1'b0;
            busy <= 1'b1;
            to_clear <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // One extra cycle after the last write so ready never overlaps a clear write.
                    if (ptr == (AW + 1)'(N)) begin
                        vm_we <= 1'b0;
                        key_ready <= 1'b1;
                        busy <= 1'b0;
                        cur_row <= 5'd0;
                        cur_col <= 7'd0;
                        state <= IDLE;
                    end else begin
                        vm_we <= 1'b1;
                        vm_addr <= ptr[AW-1:0];
                        vm_data <= BLANK;
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (key_valid && key_ready) begin
                        key_ready <= 1'b0;
                        vm_we <= n_we;
                        vm_addr <= wr_addr;
                        vm_data <= is_bs ? BLANK : key_ascii;
                        cur_row <= n_row;
                        cur_col <= n_col;
                        to_clear <= go_clear;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    vm_we <= 1'b0;
                    ptr <= '0;
                    to_clear <= 1'b0;
                    if (to_clear) begin
                        busy <= 1'b1;
                        state <= CLEAR;
                    end else begin
                        key_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
